// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one registered data memory (1-cycle read latency) between the
// processor port (p_*) and the debug/loader port (d_*).
//
// The processor has default priority. A starvation counter bounds how long
// the debug port can wait: after STARVE_LIMIT consecutive processor grants
// while d_req is pending, the debug port wins one cycle.
//
// Ports
//   clock                    single clock, rising-edge active
//   reset                    synchronous, active-low
//   p_req/p_wren/p_addr/p_wdata   processor request, write flag, address, data
//   p_grant/p_rvalid/p_rdata      processor grant, read return valid and data
//   p_stall                  processor pipeline stall (request not granted)
//   d_req/d_wren/d_addr/d_wdata   debug/loader request, write flag, address, data
//   d_grant/d_rvalid/d_rdata      debug grant, read return valid and data
//   address_dmem/data/wren   memory address, write data, write enable
//   q_dmem                   memory read data, valid one cycle after address
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_grant,
    output logic              p_rvalid,
    output logic              p_stall,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_wren,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  cnt_p0;
    logic [ADDR_W-1:0] addr_hold_p0;
    logic [DATA_W-1:0] data_hold_p0;
    logic              p_vld_p1;
    logic              d_vld_p1;
    logic [DATA_W-1:0] p_rdata_hold_p1;
    logic [DATA_W-1:0] d_rdata_hold_p1;

    // Stage p0: combinational arbitration and memory drive
    always_comb begin
        p_grant      = reset && p_req && (!d_req || (cnt_p0 < LIMIT));
        d_grant      = reset && d_req && (!p_req || (cnt_p0 == LIMIT));
        p_stall      = p_req && !p_grant;
        wren         = (p_grant && p_wren) || (d_grant && d_wren);
        address_dmem = addr_hold_p0;
        data         = data_hold_p0;
        if (p_grant) begin
            address_dmem = p_addr;
            data         = p_wdata;
        end else if (d_grant) begin
            address_dmem = d_addr;
            data         = d_wdata;
        end
    end

    // The memory bus keeps its last driven value on idle cycles.
    always_ff @(posedge clock) begin
        addr_hold_p0 <= address_dmem;
        data_hold_p0 <= data;
    end

    // Stage p1: read return, one cycle after the granting cycle
    always_comb begin
        // A reset landing on the return cycle kills the return immediately.
        p_rvalid = p_vld_p1 && reset;
        d_rvalid = d_vld_p1 && reset;
        p_rdata  = p_rvalid ? q_dmem : p_rdata_hold_p1;
        d_rdata  = d_rvalid ? q_dmem : d_rdata_hold_p1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_p0          <= '0;
            p_vld_p1        <= 1'b0;
            d_vld_p1        <= 1'b0;
            p_rdata_hold_p1 <= '0;
            d_rdata_hold_p1 <= '0;
        end else begin
            // Counts processor wins while debug waits; saturates at the limit.
            if (d_grant || !d_req) begin
                cnt_p0 <= '0;
            end else if (p_grant && (cnt_p0 != LIMIT)) begin
                cnt_p0 <= cnt_p0 + 1'b1;
            end
            p_vld_p1        <= p_grant && !p_wren;
            d_vld_p1        <= d_grant && !d_wren;
            p_rdata_hold_p1 <= p_rdata;
            d_rdata_hold_p1 <= d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a registered 4096x32 memory model.
// Inputs change 1 time unit after the rising edge; outputs are compared
// mid-cycle, so combinational grants and registered returns are both stable.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        p_req, p_wren, d_req, d_wren;
    logic [11:0] p_addr, d_addr;
    logic [31:0] p_wdata, d_wdata;
    logic        p_grant, p_rvalid, p_stall, d_grant, d_rvalid;
    logic [31:0] p_rdata, d_rdata;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_grant(p_grant), .p_rvalid(p_rvalid), .p_stall(p_stall), .p_rdata(p_rdata),
        .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
    );

    // Registered memory, read-before-write on the same address.
    always @(posedge clock) begin
        if (wren) mem[address_dmem] <= data;
        q_dmem <= mem[address_dmem];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_p(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] wd);
        p_req = req; p_wren = wr; p_addr = a; p_wdata = wd;
    endtask

    task automatic set_d(input logic req, input logic wr, input logic [11:0] a, input logic [31:0] wd);
        d_req = req; d_wren = wr; d_addr = a; d_wdata = wd;
    endtask

    task automatic idle();
        set_p(1'b0, 1'b0, 12'h000, 32'h0);
        set_d(1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        cyc();
        cyc();
        // In reset: grants forced low, stall follows request, returns cleared
        set_p(1'b1, 1'b0, 12'h010, 32'h0);
        settle();
        check_val("rst_p_grant", {31'b0, p_grant}, 32'd0);
        check_val("rst_p_stall", {31'b0, p_stall}, 32'd1);
        check_val("rst_wren", {31'b0, wren}, 32'd0);
        check_val("rst_p_rvalid", {31'b0, p_rvalid}, 32'd0);
        check_val("rst_p_rdata", p_rdata, 32'd0);
        check_val("rst_d_rdata", d_rdata, 32'd0);

        // First cycle out of reset: processor writes arbitrate immediately
        cyc(); reset = 1'b1; idle();
        set_p(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        settle();
        check_val("wr_p_grant", {31'b0, p_grant}, 32'd1);
        check_val("wr_wren", {31'b0, wren}, 32'd1);
        check_val("wr_addr", {20'b0, address_dmem}, 32'h010);
        check_val("wr_data", data, 32'hDEADBEEF);
        cyc(); set_p(1'b1, 1'b1, 12'h001, 32'hA5A50001);
        settle();
        check_val("wr_no_rvalid", {31'b0, p_rvalid}, 32'd0);
        cyc(); set_p(1'b1, 1'b1, 12'h002, 32'h5A5A0002);
        cyc(); idle();
        settle();
        check_val("idle_wren", {31'b0, wren}, 32'd0);
        check_val("idle_addr_hold", {20'b0, address_dmem}, 32'h002);
        check_val("idle_data_hold", data, 32'h5A5A0002);

        // Processor read of 0x010
        cyc(); set_p(1'b1, 1'b0, 12'h010, 32'h0);
        settle();
        check_val("s1_p_grant", {31'b0, p_grant}, 32'd1);
        check_val("s1_d_grant", {31'b0, d_grant}, 32'd0);
        check_val("s1_wren", {31'b0, wren}, 32'd0);
        cyc(); idle();
        settle();
        check_val("s1_p_rvalid", {31'b0, p_rvalid}, 32'd1);
        check_val("s1_p_rdata", p_rdata, 32'hDEADBEEF);
        check_val("s1_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        cyc();
        settle();
        check_val("s1_rvalid_once", {31'b0, p_rvalid}, 32'd0);
        check_val("s1_rdata_hold", p_rdata, 32'hDEADBEEF);

        // Both requesting for 10 cycles: P,P,P,P,D,P,P,P,P,D
        for (int i = 0; i < 10; i++) begin
            logic exp_d;
            cyc();
            set_p(1'b1, 1'b0, 12'h001, 32'h0);
            set_d(1'b1, 1'b0, 12'h002, 32'h0);
            settle();
            exp_d = (i == 4) || (i == 9);
            check_val($sformatf("starve_p_grant_%0d", i), {31'b0, p_grant}, {31'b0, !exp_d});
            check_val($sformatf("starve_d_grant_%0d", i), {31'b0, d_grant}, {31'b0, exp_d});
            check_val($sformatf("starve_p_stall_%0d", i), {31'b0, p_stall}, {31'b0, exp_d});
            if (i == 5) begin
                check_val("starve_d_rvalid", {31'b0, d_rvalid}, 32'd1);
                check_val("starve_d_rdata", d_rdata, 32'h5A5A0002);
                check_val("starve_p_rvalid", {31'b0, p_rvalid}, 32'd0);
            end
        end

        // Processor drops: debug wins alone
        cyc(); idle(); set_d(1'b1, 1'b0, 12'h010, 32'h0);
        settle();
        check_val("s2_d_grant", {31'b0, d_grant}, 32'd1);
        check_val("s2_p_grant", {31'b0, p_grant}, 32'd0);
        check_val("s2_d_rdata_prev", d_rdata, 32'h5A5A0002);
        cyc(); idle();
        settle();
        check_val("s2_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check_val("s2_d_rdata", d_rdata, 32'hDEADBEEF);
        check_val("s2_p_rvalid", {31'b0, p_rvalid}, 32'd0);

        // Debug write 0xFFF then processor read 0xFFF
        cyc(); idle(); set_d(1'b1, 1'b1, 12'hFFF, 32'h12345678);
        settle();
        check_val("s4_d_grant", {31'b0, d_grant}, 32'd1);
        check_val("s4_wren_t", {31'b0, wren}, 32'd1);
        check_val("s4_addr", {20'b0, address_dmem}, 32'hFFF);
        cyc(); idle(); set_p(1'b1, 1'b0, 12'hFFF, 32'h0);
        settle();
        check_val("s4_wren_t1", {31'b0, wren}, 32'd0);
        check_val("s4_d_rvalid_t1", {31'b0, d_rvalid}, 32'd0);
        cyc(); idle();
        settle();
        check_val("s4_p_rvalid", {31'b0, p_rvalid}, 32'd1);
        check_val("s4_p_rdata", p_rdata, 32'h12345678);
        check_val("s4_d_rvalid_t2", {31'b0, d_rvalid}, 32'd0);

        // Back-to-back reads from alternating ports
        cyc(); idle(); set_p(1'b1, 1'b0, 12'h001, 32'h0);
        cyc(); idle(); set_d(1'b1, 1'b0, 12'h002, 32'h0);
        settle();
        check_val("s6_d_grant", {31'b0, d_grant}, 32'd1);
        check_val("s6_p_rvalid", {31'b0, p_rvalid}, 32'd1);
        check_val("s6_p_rdata", p_rdata, 32'hA5A50001);
        check_val("s6_d_rvalid_t1", {31'b0, d_rvalid}, 32'd0);
        cyc(); idle();
        settle();
        check_val("s6_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check_val("s6_d_rdata", d_rdata, 32'h5A5A0002);
        check_val("s6_p_rvalid_t2", {31'b0, p_rvalid}, 32'd0);

        // Processor read, debug waiting (counter to 1), then reset
        cyc(); set_p(1'b1, 1'b0, 12'h010, 32'h0); set_d(1'b1, 1'b0, 12'h002, 32'h0);
        settle();
        check_val("s5_p_grant", {31'b0, p_grant}, 32'd1);
        cyc(); reset = 1'b0;
        settle();
        check_val("s5_p_rvalid_t1", {31'b0, p_rvalid}, 32'd0);
        check_val("s5_p_grant_rst", {31'b0, p_grant}, 32'd0);
        check_val("s5_d_grant_rst", {31'b0, d_grant}, 32'd0);
        check_val("s5_wren_rst", {31'b0, wren}, 32'd0);
        check_val("s5_p_stall_rst", {31'b0, p_stall}, 32'd1);

        // Out of reset the counter restarts at 0: P,P,P,P,D
        for (int i = 0; i < 5; i++) begin
            logic exp_d;
            cyc(); reset = 1'b1;
            set_p(1'b1, 1'b0, 12'h001, 32'h0);
            set_d(1'b1, 1'b0, 12'h002, 32'h0);
            settle();
            exp_d = (i == 4);
            if (i == 0) begin
                check_val("s5_p_rvalid_t2", {31'b0, p_rvalid}, 32'd0);
                check_val("s5_p_rdata_clr", p_rdata, 32'd0);
                check_val("s5_d_rdata_clr", d_rdata, 32'd0);
            end
            check_val($sformatf("post_rst_p_grant_%0d", i), {31'b0, p_grant}, {31'b0, !exp_d});
            check_val($sformatf("post_rst_d_grant_%0d", i), {31'b0, d_grant}, {31'b0, exp_d});
        end
        cyc(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
